// File: rtl/pipe_stall_sequencer.sv
// Pipeline hazard sequencer: turns stall/mispredict requests into PC and IF/ID write
// enables plus flush strobes, with a post-reset fill hold and hazard statistics.
//
// state | meaning
// INIT  | post-reset fill: PC held, IF/ID and ID/EX flushed, inputs ignored
// RUN   | normal issue; mispredict beats stall_req
// FLUSH | remainder of the mispredict flush window, inputs ignored
// (3)   | illegal encoding, recovers to INIT
module pipe_stall_sequencer #(
    parameter int STARTUP_CYCLES = 3,
    parameter int FLUSH_CYCLES   = 2,
    parameter int STALL_LIMIT    = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             mispredict,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             stall_timeout
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam int SU_W = $clog2(STARTUP_CYCLES + 1);
    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
    localparam int CS_W = $clog2(STALL_LIMIT + 1);

    localparam logic [SU_W-1:0] SU_LAST   = SU_W'(STARTUP_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST   = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [CS_W-1:0] STALL_LIM = CS_W'(STALL_LIMIT);

    state_t           state, state_nx;
    logic [SU_W-1:0]  startup_cnt, startup_nx;
    logic [FL_W-1:0]  flush_cnt, flush_nx;
    logic [CS_W-1:0]  consec_cnt, consec_nx;
    logic             stall_inc, flush_inc, timeout_set;

    always_comb begin
        state_nx    = state;
        startup_nx  = startup_cnt;
        flush_nx    = flush_cnt;
        consec_nx   = consec_cnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        timeout_set = 1'b0;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;

        case (state)
            ST_INIT: begin
                startup_nx = startup_cnt + SU_W'(1);
                if (startup_cnt == SU_LAST) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mispredict) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    flush_inc  = 1'b1;
                    consec_nx  = '0;
                    if (FLUSH_CYCLES > 1) begin
                        state_nx = ST_FLUSH;
                        flush_nx = FL_W'(1);
                    end
                end else if (stall_req) begin
                    ifid_flush = 1'b0;
                    stall_inc  = 1'b1;
                    if (consec_cnt != STALL_LIM) begin
                        consec_nx = consec_cnt + CS_W'(1);
                    end
                    if (consec_nx == STALL_LIM) begin
                        timeout_set = 1'b1;
                    end
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = 1'b0;
                    idex_flush = 1'b0;
                    consec_nx  = '0;
                end
            end
            ST_FLUSH: begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                flush_nx   = flush_cnt + FL_W'(1);
                if (flush_cnt == FL_LAST) begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx   = ST_INIT;
                startup_nx = '0;
            end
        endcase

        // Reset held low overrides whatever the state register still shows.
        if (!reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_INIT;
            startup_cnt   <= '0;
            flush_cnt     <= '0;
            consec_cnt    <= '0;
            stall_count   <= '0;
            flush_count   <= '0;
            stall_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            startup_cnt <= startup_nx;
            flush_cnt   <= flush_nx;
            consec_cnt  <= consec_nx;
            if (stall_inc && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush_inc && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            if (timeout_set) begin
                stall_timeout <= 1'b1;
            end
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Directed bench: instance a uses default parameters, instance b uses
// STALL_LIMIT=4, CNT_W=3, FLUSH_CYCLES=4 for timeout, saturation and reset-mid-flush.
module tb_pipe_stall_sequencer;

    logic clock;
    logic ra, sa, ma;
    logic rb, sb, mb;

    logic        pcw_a, ifw_a, iff_a, ief_a, to_a;
    logic [1:0]  st_a;
    logic [15:0] sc_a, fc_a;

    logic        pcw_b, ifw_b, iff_b, ief_b, to_b;
    logic [1:0]  st_b;
    logic [2:0]  sc_b, fc_b;

    int vectors = 0;
    int miscompares = 0;

    pipe_stall_sequencer dut_a (
        .clock(clock), .reset(ra), .stall_req(sa), .mispredict(ma),
        .pc_write(pcw_a), .ifid_write(ifw_a), .ifid_flush(iff_a), .idex_flush(ief_a),
        .seq_state(st_a), .stall_count(sc_a), .flush_count(fc_a), .stall_timeout(to_a)
    );

    pipe_stall_sequencer #(
        .STARTUP_CYCLES(3), .FLUSH_CYCLES(4), .STALL_LIMIT(4), .CNT_W(3)
    ) dut_b (
        .clock(clock), .reset(rb), .stall_req(sb), .mispredict(mb),
        .pc_write(pcw_b), .ifid_write(ifw_b), .ifid_flush(iff_b), .idex_flush(ief_b),
        .seq_state(st_b), .stall_count(sc_b), .flush_count(fc_b), .stall_timeout(to_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        ra = 1'b0; sa = 1'b0; ma = 1'b0;
        rb = 1'b0; sb = 1'b0; mb = 1'b0;

        // reset state
        next(); next();
        #1;
        check("a_rst_state", 32'(st_a), 0);
        check("a_rst_stall_count", 32'(sc_a), 0);
        check("a_rst_flush_count", 32'(fc_a), 0);
        check("a_rst_timeout", 32'(to_a), 0);
        check("a_rst_pc_write", 32'(pcw_a), 0);
        check("a_rst_ifid_flush", 32'(iff_a), 1);

        // release with stall_req high: 3 INIT cycles
        ra = 1'b1; sa = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("a_init_state", 32'(st_a), 0);
            check("a_init_pc_write", 32'(pcw_a), 0);
            check("a_init_ifid_flush", 32'(iff_a), 1);
            check("a_init_stall_count", 32'(sc_a), 0);
            next();
        end
        check("a_run_state", 32'(st_a), 1);
        check("a_run_stall_count", 32'(sc_a), 0);

        // 5 stall cycles in RUN (cycle 4 is the first)
        for (int i = 0; i < 5; i++) begin
            check("a_stall_pc_write", 32'(pcw_a), 0);
            check("a_stall_ifid_write", 32'(ifw_a), 0);
            check("a_stall_ifid_flush", 32'(iff_a), 0);
            check("a_stall_idex_flush", 32'(ief_a), 1);
            next();
        end
        sa = 1'b0;
        #1;
        check("a_after_stall_pc_write", 32'(pcw_a), 1);
        check("a_after_stall_ifid_write", 32'(ifw_a), 1);
        check("a_after_stall_idex_flush", 32'(ief_a), 0);
        check("a_stall_count_5", 32'(sc_a), 5);
        check("a_stall_timeout_0", 32'(to_a), 0);
        next();

        // mispredict together with stall
        sa = 1'b1; ma = 1'b1;
        #1;
        check("a_mp_pc_write", 32'(pcw_a), 1);
        check("a_mp_ifid_flush", 32'(iff_a), 1);
        check("a_mp_idex_flush", 32'(ief_a), 1);
        next();
        ma = 1'b0; sa = 1'b1;
        #1;
        check("a_flush_state", 32'(st_a), 2);
        check("a_flush_pc_write", 32'(pcw_a), 1);
        check("a_flush_ifid_flush", 32'(iff_a), 1);
        check("a_flush_idex_flush", 32'(ief_a), 1);
        check("a_flush_count_1", 32'(fc_a), 1);
        next();
        sa = 1'b0;
        #1;
        check("a_back_run_state", 32'(st_a), 1);
        check("a_flush_count_still_1", 32'(fc_a), 1);
        check("a_stall_count_still_5", 32'(sc_a), 5);
        check("a_back_run_idex_flush", 32'(ief_a), 0);

        // mispredict during FLUSH is ignored
        ma = 1'b1;
        next();
        #1;
        check("a_flush2_state", 32'(st_a), 2);
        check("a_flush_count_2", 32'(fc_a), 2);
        next();
        ma = 1'b0;
        #1;
        check("a_flush2_exit_state", 32'(st_a), 1);
        check("a_flush_count_2_hold", 32'(fc_a), 2);

        // instance b: release and fill
        rb = 1'b1;
        next(); next(); next();
        check("b_run_state", 32'(st_b), 1);

        // timeout: 3 stalls, gap, 4 stalls
        sb = 1'b1;
        next(); next(); next();
        sb = 1'b0;
        #1;
        check("b_to_after_3", 32'(to_b), 0);
        check("b_sc_after_3", 32'(sc_b), 3);
        next();
        for (int i = 0; i < 4; i++) begin
            sb = 1'b1;
            #1;
            check("b_to_during_run2", 32'(to_b), 0);
            next();
        end
        sb = 1'b0;
        #1;
        check("b_to_set", 32'(to_b), 1);
        check("b_sc_7", 32'(sc_b), 7);
        next();
        check("b_to_sticky", 32'(to_b), 1);

        // full 4-cycle flush window
        mb = 1'b1;
        #1;
        check("b_mp_idex_flush", 32'(ief_b), 1);
        check("b_mp_pc_write", 32'(pcw_b), 1);
        next();
        mb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("b_flush_state", 32'(st_b), 2);
            next();
        end
        check("b_flush_exit_state", 32'(st_b), 1);
        check("b_flush_count_1", 32'(fc_b), 1);

        // reset in the 2nd flush cycle
        mb = 1'b1;
        next();
        mb = 1'b0;
        #1;
        check("b_mid_flush_state", 32'(st_b), 2);
        next();
        rb = 1'b0;
        #1;
        check("b_rst_forced_pc_write", 32'(pcw_b), 0);
        check("b_rst_forced_ifid_write", 32'(ifw_b), 0);
        check("b_rst_forced_ifid_flush", 32'(iff_b), 1);
        check("b_pre_rst_flush_count", 32'(fc_b), 2);
        next();
        check("b_rst_state", 32'(st_b), 0);
        check("b_rst_stall_count", 32'(sc_b), 0);
        check("b_rst_flush_count", 32'(fc_b), 0);
        check("b_rst_timeout", 32'(to_b), 0);
        rb = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("b_reinit_state", 32'(st_b), 0);
            check("b_reinit_pc_write", 32'(pcw_b), 0);
            next();
        end
        check("b_rerun_state", 32'(st_b), 1);
        check("b_rerun_pc_write", 32'(pcw_b), 1);

        // 9 isolated stalls saturate a 3-bit counter
        for (int i = 0; i < 9; i++) begin
            sb = 1'b1;
            next();
            sb = 1'b0;
            next();
        end
        check("b_sat_stall_count", 32'(sc_b), 7);
        check("b_sat_timeout", 32'(to_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
